// File: rtl/udm_seq_div.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
module udm_seq_div #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero
);

   localparam int DW = 2 * WIDTH;
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   state_t            state_next;
   logic [CW-1:0]     count;
   logic [WIDTH:0]    part_rem;
   logic [DW-1:0]     shreg;
   logic [WIDTH-1:0]  div_q;
   logic [WIDTH+1:0]  shifted;
   logic [WIDTH+1:0]  diff;
   logic              qbit;
   logic [WIDTH:0]    rem_next;
   logic [DW-1:0]     shreg_next;
   logic              accept;
   logic              last_step;

   assign accept    = (state == IDLE) && in_valid;
   assign last_step = (state == RUN) && (count == LAST);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // One restoring step; the extra top bit of diff acts as the sign of the trial subtraction.
   always_comb begin
      shifted    = {part_rem, shreg[DW-1]};
      diff       = shifted - {2'b00, div_q};
      qbit       = ~diff[WIDTH+1];
      rem_next   = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
      shreg_next = {shreg[DW-2:0], qbit};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = (divisor == '0) ? DONE : RUN;
         RUN:     if (count == LAST) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result registers only change at accept (zero divisor) or on the final step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         part_rem    <= '0;
         shreg       <= '0;
         div_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         count    <= '0;
         part_rem <= '0;
         shreg    <= dividend;
         div_q    <= divisor;
         if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         count    <= count + 1'b1;
         part_rem <= rem_next;
         shreg    <= shreg_next;
         if (last_step) begin
            quotient    <= shreg_next;
            remainder   <= rem_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_udm_seq_div.sv
// Directed and exhaustive checks of udm_seq_div at WIDTH=4.
module tb_udm_seq_div;

   localparam int WIDTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int compared = 0;
   int mismatched = 0;

   udm_seq_div #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Operands are scrambled right after the accept edge so a design using live inputs is caught.
   task automatic start_op(input logic [7:0] a, input logic [3:0] b, output time t_acc);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid = 1'b0;
      dividend = ~a;
      divisor  = b + 4'd1;
   endtask

   task automatic wait_done(output int lat, output int busy_ready);
      lat = 0;
      busy_ready = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ready++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_directed(input string tag, input logic [7:0] a, input logic [3:0] b,
                               input logic [7:0] eq, input logic [3:0] er, input logic ez,
                               input int elat);
      time t;
      int  lat;
      int  busy;
      start_op(a, b, t);
      wait_done(lat, busy);
      check({tag, " latency"}, lat, elat);
      check({tag, " in_ready busy"}, busy, 0);
      check({tag, " out_valid"}, out_valid, 1);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, div_by_zero, ez);
   endtask

   initial begin
      time        t_acc;
      time        t_prev;
      int         lat;
      int         busy;
      int         pulses;
      logic [7:0] tv_a [3];
      logic [3:0] tv_b [3];
      logic [7:0] tv_q [3];
      logic [7:0] eq;
      logic [3:0] er;
      logic       ez;
      logic [7:0] elat;

      t_prev = 0;
      #1 rst = 1'b1;
      #2;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset div_by_zero", div_by_zero, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_directed("200/7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
      release_result();
      check("200/7 back to idle", in_ready, 1);

      run_directed("123/0", 8'd123, 4'd0, 8'hFF, 4'd0, 1'b1, 0);
      release_result();

      // Back-to-back with the consumer always ready.
      tv_a = '{8'd255, 8'd15, 8'd0};
      tv_b = '{4'd15, 4'd15, 4'd5};
      tv_q = '{8'd17, 8'd1, 8'd0};
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start_op(tv_a[k], tv_b[k], t_acc);
         wait_done(lat, busy);
         check($sformatf("b2b%0d latency", k), lat, 8);
         check($sformatf("b2b%0d in_ready busy", k), busy, 0);
         check($sformatf("b2b%0d quotient", k), quotient, tv_q[k]);
         check($sformatf("b2b%0d remainder", k), remainder, 0);
         check($sformatf("b2b%0d div_by_zero", k), div_by_zero, 0);
         if (k > 0) check($sformatf("b2b%0d accept spacing", k), 32'((t_acc - t_prev) / 10), 10);
         t_prev = t_acc;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;

      // Consumer stalls; in_valid pulses with new operands must be ignored.
      start_op(8'd200, 4'd7, t_acc);
      wait_done(lat, busy);
      check("stall latency", lat, 8);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         dividend = 8'd1;
         divisor  = 4'd1;
         @(posedge clk);
         #1;
         check($sformatf("stall%0d out_valid", i), out_valid, 1);
         check($sformatf("stall%0d quotient", i), quotient, 28);
         check($sformatf("stall%0d remainder", i), remainder, 4);
         check($sformatf("stall%0d in_ready", i), in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("no bypass in_ready", in_ready, 1);
      check("no bypass out_valid", out_valid, 0);
      check("idle holds quotient", quotient, 28);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("accept after idle", in_ready, 0);
      wait_done(lat, busy);
      check("1/1 latency", lat, 8);
      check("1/1 quotient", quotient, 1);
      check("1/1 remainder", remainder, 0);
      release_result();

      // Asynchronous reset in the middle of RUN.
      start_op(8'd200, 4'd7, t_acc);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("abort in_ready", in_ready, 1);
      check("abort out_valid", out_valid, 0);
      check("abort quotient", quotient, 0);
      check("abort remainder", remainder, 0);
      check("abort div_by_zero", div_by_zero, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      pulses = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) pulses++;
      end
      check("abort no out_valid pulse", pulses, 0);
      check("abort idle", in_ready, 1);
      run_directed("99/9", 8'd99, 4'd9, 8'd11, 4'd0, 1'b0, 8);
      release_result();

      // Every operand pair, visited in a scrambled order.
      for (int i = 0; i < 4096; i++) begin
         int         p;
         logic [7:0] a;
         logic [3:0] b;
         p = (i * 2897) % 4096;
         a = p[11:4];
         b = p[3:0];
         if (b == 4'd0) begin
            eq = 8'hFF; er = 4'd0; ez = 1'b1; elat = 8'd0;
         end else begin
            eq = a / b; er = 4'(a % b); ez = 1'b0; elat = 8'd8;
         end
         start_op(a, b, t_acc);
         wait_done(lat, busy);
         check($sformatf("sweep %0d/%0d", a, b),
               {11'd0, quotient, remainder, div_by_zero, 8'(lat)},
               {11'd0, eq, er, ez, elat});
         release_result();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, observed hang expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
